// File: rtl/pe_slot_sched.sv
// ============================================================================
// Module   : pe_slot_sched
// Brief    : Shares one router PE port between NSLOT PE FSM slots: locked
//            input dispatch, packet-locked round-robin output arbitration.
//            Optional statistics outputs under `PE_SCHED_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_slot_sched #(
    parameter int NSLOT = 2,
    parameter int DATAW = 64,
    parameter int VCW   = 1
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [DATAW-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_rdy,
    input  logic [NSLOT-1:0]       slot_busy,
    output logic [DATAW-1:0]       slot_data,
    output logic [NSLOT-1:0]       slot_valid,
    input  logic [NSLOT-1:0]       slot_req,
    input  logic [NSLOT-1:0]       slot_last,
    input  logic [NSLOT*VCW-1:0]   slot_vch,
    input  logic [(2**VCW)-1:0]    net_rdy,
    output logic [NSLOT-1:0]       slot_grt,
    output logic [NSLOT-1:0]       out_sel
`ifdef PE_SCHED_STAT_EN
    ,
    output logic [15:0]            pkt_cnt,
    output logic [15:0]            stall_cnt,
    output logic                   err_flag
`endif
);

    localparam int IDXW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [1:0] FT_HEAD   = 2'b00;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    logic            in_lock_q, in_lock_d;
    logic [IDXW-1:0] in_slot_q, in_slot_d;
    logic            out_lock_q;
    logic [IDXW-1:0] out_owner_q;
    logic [IDXW-1:0] rr_ptr_q;
    logic [NSLOT-1:0] out_sel_q;

    logic [1:0]       ftype;
    logic             is_start;
    logic [IDXW-1:0]  tgt;
    logic             legal;
    logic             rdy;
    logic             accept;
    logic [NSLOT-1:0] elig;
    logic             gnt_ok;
    logic [IDXW-1:0]  gnt_idx;
    logic [IDXW:0]    scan;

    assign ftype     = in_data[DATAW-1 -: 2];
    assign is_start  = (ftype == FT_HEAD) || (ftype == FT_SINGLE);
    assign slot_data = in_data;

    // Input dispatch: a locked packet keeps its slot regardless of slot_busy.
    always_comb begin
        tgt   = '0;
        legal = 1'b0;
        rdy   = 1'b0;
        if (in_lock_q) begin
            tgt   = in_slot_q;
            legal = 1'b1;
            rdy   = 1'b1;
        end else if (is_start) begin
            for (int i = NSLOT - 1; i >= 0; i--) begin
                if (!slot_busy[i]) begin
                    tgt   = IDXW'(i);
                    legal = 1'b1;
                end
            end
            rdy = legal;
        end else begin
            rdy = 1'b1;
        end
        if (rst_) begin
            rdy   = 1'b0;
            legal = 1'b0;
        end
    end

    assign in_rdy     = rdy;
    assign accept     = in_valid & rdy;
    assign slot_valid = (accept & legal) ? (NSLOT'(1) << tgt) : '0;

    always_comb begin
        in_lock_d = in_lock_q;
        in_slot_d = in_slot_q;
        if (accept && legal) begin
            if (ftype == FT_HEAD) begin
                in_lock_d = 1'b1;
                in_slot_d = tgt;
            end else if (ftype == FT_TAIL) begin
                in_lock_d = 1'b0;
            end
        end
    end

    // Output arbitration; descending scan so the nearest slot after rr_ptr wins.
    always_comb begin
        elig    = '0;
        gnt_ok  = 1'b0;
        gnt_idx = out_owner_q;
        scan    = '0;
        for (int i = 0; i < NSLOT; i++) begin
            elig[i] = slot_req[i] & net_rdy[slot_vch[i*VCW +: VCW]];
        end
        if (out_lock_q) begin
            gnt_ok = elig[out_owner_q];
        end else begin
            for (int k = NSLOT; k >= 1; k--) begin
                scan = {1'b0, rr_ptr_q} + (IDXW+1)'(k);
                if (scan >= (IDXW+1)'(NSLOT)) begin
                    scan = scan - (IDXW+1)'(NSLOT);
                end
                if (elig[scan[IDXW-1:0]]) begin
                    gnt_ok  = 1'b1;
                    gnt_idx = scan[IDXW-1:0];
                end
            end
        end
        if (rst_) begin
            gnt_ok = 1'b0;
        end
    end

    assign slot_grt = gnt_ok ? (NSLOT'(1) << gnt_idx) : '0;
    assign out_sel  = out_sel_q;

    always_ff @(posedge clk) begin
        if (rst_) begin
            in_lock_q   <= 1'b0;
            in_slot_q   <= '0;
            out_lock_q  <= 1'b0;
            out_owner_q <= '0;
            rr_ptr_q    <= IDXW'(NSLOT - 1);
            out_sel_q   <= '0;
        end else begin
            in_lock_q <= in_lock_d;
            in_slot_q <= in_slot_d;
            out_sel_q <= slot_grt;
            if (gnt_ok) begin
                rr_ptr_q <= gnt_idx;
                if (slot_last[gnt_idx]) begin
                    out_lock_q <= 1'b0;
                end else begin
                    out_lock_q  <= 1'b1;
                    out_owner_q <= gnt_idx;
                end
            end
        end
    end

`ifdef PE_SCHED_STAT_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] stall_cnt_q;
    logic        err_flag_q;

    always_ff @(posedge clk) begin
        if (rst_) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
            err_flag_q  <= 1'b0;
        end else begin
            if (accept && legal && is_start && (pkt_cnt_q != 16'hFFFF)) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (in_valid && !rdy && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (accept && !legal) begin
                err_flag_q <= 1'b1;
            end
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign err_flag  = err_flag_q;
`endif

endmodule

`default_nettype wire

// File: doc/pe_slot_sched.md
Name: pe_slot_sched

Overview:
- Controller that shares one router-facing PE port between NSLOT independent PE FSM slots.
- Input side: dispatches each incoming packet to one free slot and keeps it locked to that slot from head flit to tail flit.
- Output side: round-robin arbitration of slot send requests, gated by per-VC ready, with the grant held for a whole packet. Drives the registered output-mux select.
- Sits between the router local port and the PE FSM slots, replacing ad-hoc two-slot select and mux logic.

Parameters:
- NSLOT, 2, number of PE FSM slots (2..8).
- DATAW, 64, flit width; bits [DATAW-1:DATAW-2] are the flit type: 00 head, 01 body, 10 tail, 11 single.
- VCW, 1, VC id width; number of VCs NVC = 2**VCW.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_  in  1  synchronous reset, active-high.
- in_data  in  DATAW  flit from router.
- in_valid  in  1  in_data valid.
- in_rdy  out  1  flit accepted when in_valid & in_rdy.
- slot_busy  in  NSLOT  slot i cannot take a new packet (computing or sending).
- slot_data  out  DATAW  in_data broadcast to all slots.
- slot_valid  out  NSLOT  one-hot; flit delivered to slot i.
- slot_req  in  NSLOT  slot i wants to send one flit.
- slot_last  in  NSLOT  slot i's current output flit is tail or single.
- slot_vch  in  NSLOT*VCW  target VC of slot i, slot i at [i*VCW +: VCW].
- net_rdy  in  NVC  per-VC downstream ready.
- slot_grt  out  NSLOT  one-hot send grant.
- out_sel  out  NSLOT  registered one-hot output-mux select; 0 means idle.

Behaviour:
- Reset values, synchronous on rst_ = 1:
  - in_lock = 0, in_slot = 0, out_lock = 0, out_owner = 0.
  - rr_ptr = NSLOT-1, so slot 0 has first priority.
  - out_sel = 0.
  - Combinational outputs are 0 while rst_ = 1.
- Reset mid-packet drops all locks. The partial packet is abandoned; slot cleanup is the slots' responsibility.
- Input dispatch (combinational path from in_* to slot_valid, 0-cycle latency):
  - With no input lock and a head or single flit:
    - target = lowest index i with slot_busy[i] = 0.
    - If no such i, in_rdy = 0.
  - With no input lock and a body or tail flit: protocol error.
    - in_rdy = 1; the flit is dropped; no slot_valid.
  - With the input lock set: target = in_slot, in_rdy = 1 regardless of slot_busy (packet continuation).
  - slot_valid[target] = in_valid & in_rdy, for legal flits only.
  - slot_data = in_data at all times.
- Input lock update on an accepted flit:
  - head: in_lock <= 1, in_slot <= target.
  - tail: in_lock <= 0.
  - single: no change.
  - body: no change.
- Output arbitration:
  - elig[i] = slot_req[i] & net_rdy[vch_i].
  - Unlocked: grant the first eligible slot scanning rr_ptr+1, rr_ptr+2, … with wrap-around modulo NSLOT. On a grant, rr_ptr <= granted index.
  - Locked: only out_owner may be granted, when elig[out_owner]. Other slots get no grant even if eligible.
  - On grant to i with slot_last[i] = 0: out_lock <= 1, out_owner <= i.
  - On grant with slot_last[i] = 1: out_lock <= 0.
  - Owner drops slot_req, or its VC is not ready: no grant that cycle, lock held (stall, no reallocation).
  - out_sel <= slot_grt every cycle. The slot drives its flit the cycle after the grant; out_sel = 0 on cycles with no grant.
- Simultaneous events:
  - Input and output sides are independent.
  - A slot may receive input and be granted in the same cycle.
  - slot_busy changing during a locked input packet has no effect.
- Invariants checked by the bench:
  - slot_valid and slot_grt are each one-hot or zero.
  - out_sel is one-hot or zero.

Optional Feature:
- Macro: PE_SCHED_STAT_EN.
- Defined: adds the following outputs, all cleared by rst_ and saturating (no wrap):
  - pkt_cnt, 16 bits: +1 per accepted head or single flit.
  - stall_cnt, 16 bits: +1 per cycle with in_valid & !in_rdy.
  - err_flag, 1 bit: sticky, set on a dropped orphan body or tail flit.
- Undefined: these ports and their registers do not exist. Core behaviour is identical either way.

Test Plan:
- Reset, then single flit, slot_busy = 00 → slot_valid = 01 that cycle, in_rdy = 1, no lock.
- Head with slot_busy = 01 → slot 1 locked. Next: body with slot_busy = 11 → slot_valid = 10. Then tail → lock released. Next head with slot_busy = 11 → in_rdy = 0 until a slot frees.
- NSLOT = 2, slot_req = 11 held, slot_last = 1 always, net_rdy = 11 → grants alternate 01, 10, 01, …; out_sel equals the previous cycle's grant.
- Slot 0 granted with slot_last = 0 while slot 1 is requesting → slot 1 gets no grant until slot 0 sends a tail. With net_rdy[vch0] = 0 for 3 cycles → no grants, lock held.
- Orphan body flit after reset → in_rdy = 1, slot_valid = 0. With PE_SCHED_STAT_EN: err_flag = 1, and stall_cnt reaches 5 after 5 blocked cycles.
- rst_ asserted mid-packet on both sides → next cycle in_lock = out_lock = 0, out_sel = 0. A subsequent request from slot 1 alone is granted immediately.
